// File: rtl/mor1kx_rf_wb_sched.sv
// Register-file writeback scheduler: arbitrates the single GPR write port between
// ALU results, buffered LSU load returns and debug writes; flags RAW hazards on queued loads.
module mor1kx_rf_wb_sched #(
    parameter int unsigned OPTION_RF_ADDR_WIDTH  = 5,
    parameter int unsigned OPTION_OPERAND_WIDTH  = 32,
    parameter int unsigned OPTION_LSU_FIFO_DEPTH = 2,
    parameter int unsigned OPTION_STARVE_LIMIT   = 4,
    parameter int unsigned OPTION_R0_ZERO        = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        alu_we_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]             alu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]             alu_dat_i,
    output logic                                        alu_stall_o,
    input  logic                                        lsu_valid_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]             lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]             lsu_dat_i,
    output logic                                        lsu_ready_o,
    input  logic                                        dbg_req_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]             dbg_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]             dbg_dat_i,
    output logic                                        dbg_ack_o,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]             chk_adr_a_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]             chk_adr_b_i,
    output logic                                        hazard_o,
    output logic                                        rf_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]             rf_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]             rf_dat_o,
    output logic [$clog2(OPTION_LSU_FIFO_DEPTH):0]      pending_o
);

    localparam int unsigned AW    = OPTION_RF_ADDR_WIDTH;
    localparam int unsigned DW    = OPTION_OPERAND_WIDTH;
    localparam int unsigned DEPTH = OPTION_LSU_FIFO_DEPTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = (OPTION_STARVE_LIMIT > 0) ? $clog2(OPTION_STARVE_LIMIT + 1) : 1;
    localparam logic        R0_Z  = (OPTION_R0_ZERO != 0);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_DBG  = 2'd3
    } src_e;

    logic [AW-1:0]    r_mem_adr [DEPTH];
    logic [DW-1:0]    r_mem_dat [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [STV_W-1:0] r_starve_cnt;
    logic             r_rf_we;
    logic [AW-1:0]    r_rf_adr;
    logic [DW-1:0]    r_rf_dat;
    logic             r_dbg_ack;

    logic             w_empty;
    logic             w_full;
    logic             w_starve;
    logic             w_push;
    logic             w_pop;
    logic             w_alu_stall;
    src_e             w_sel;
    logic [AW-1:0]    w_gnt_adr;
    logic [DW-1:0]    w_gnt_dat;
    logic             w_gnt_r0;
    logic             w_hazard;
    logic [PTR_W-1:0] w_off;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_starve = (r_starve_cnt == STV_W'(OPTION_STARVE_LIMIT)) && !w_empty;
    assign w_push   = lsu_valid_i && !w_full;
    assign w_pop    = (w_sel == SRC_LSU);

    // Fixed-priority grant with starvation override for the LSU head.
    // A debug grant is masked while its ack is out so a slow-dropping request cannot double-issue.
    always_comb begin
        w_sel       = SRC_NONE;
        w_alu_stall = 1'b0;
        if (w_starve) begin
            w_sel       = SRC_LSU;
            w_alu_stall = alu_we_i;
        end else if (alu_we_i) begin
            w_sel = SRC_ALU;
        end else if (!w_empty) begin
            w_sel = SRC_LSU;
        end else if (dbg_req_i && !r_dbg_ack) begin
            w_sel = SRC_DBG;
        end
    end

    always_comb begin
        w_gnt_adr = '0;
        w_gnt_dat = '0;
        case (w_sel)
            SRC_ALU: begin
                w_gnt_adr = alu_adr_i;
                w_gnt_dat = alu_dat_i;
            end
            SRC_LSU: begin
                w_gnt_adr = r_mem_adr[r_rd_ptr];
                w_gnt_dat = r_mem_dat[r_rd_ptr];
            end
            SRC_DBG: begin
                w_gnt_adr = dbg_adr_i;
                w_gnt_dat = dbg_dat_i;
            end
            default: begin
                w_gnt_adr = '0;
                w_gnt_dat = '0;
            end
        endcase
    end

    assign w_gnt_r0 = R0_Z && (w_gnt_adr == '0);

    // Hazard scan over live entries only; offset from the read pointer decides liveness.
    always_comb begin
        w_hazard = 1'b0;
        w_off    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rd_ptr;
            if ((CNT_W'(w_off) < r_count)
                && !(R0_Z && (r_mem_adr[i] == '0))
                && ((r_mem_adr[i] == chk_adr_a_i) || (r_mem_adr[i] == chk_adr_b_i))) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Payload storage carries no reset; liveness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_adr[r_wr_ptr] <= lsu_adr_i;
            r_mem_dat[r_wr_ptr] <= lsu_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts cycles the LSU head waits behind the ALU; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STV_W'(OPTION_STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + STV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_adr  <= '0;
            r_rf_dat  <= '0;
            r_dbg_ack <= 1'b0;
        end else begin
            r_rf_we   <= (w_sel != SRC_NONE) && !w_gnt_r0;
            r_dbg_ack <= (w_sel == SRC_DBG);
            if (w_sel != SRC_NONE) begin
                r_rf_adr <= w_gnt_adr;
                r_rf_dat <= w_gnt_dat;
            end
        end
    end

    assign alu_stall_o = w_alu_stall;
    assign lsu_ready_o = !w_full;
    assign dbg_ack_o   = r_dbg_ack;
    assign hazard_o    = w_hazard;
    assign rf_we_o     = r_rf_we;
    assign rf_adr_o    = r_rf_adr;
    assign rf_dat_o    = r_rf_dat;
    assign pending_o   = r_count;

endmodule

// File: tb/tb_mor1kx_rf_wb_sched.sv
// Scoreboard bench for mor1kx_rf_wb_sched: directed stimulus queues expected RF writes,
// a negedge monitor pops and compares them; status outputs are checked inline.
module tb_mor1kx_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_adr;
    logic [31:0] alu_dat;
    logic        alu_stall;
    logic        lsu_valid;
    logic [4:0]  lsu_adr;
    logic [31:0] lsu_dat;
    logic        lsu_ready;
    logic        dbg_req;
    logic [4:0]  dbg_adr;
    logic [31:0] dbg_dat;
    logic        dbg_ack;
    logic [4:0]  chk_a;
    logic [4:0]  chk_b;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_adr;
    logic [31:0] rf_dat;
    logic [1:0]  pending;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    mor1kx_rf_wb_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_we_i    (alu_we),
        .alu_adr_i   (alu_adr),
        .alu_dat_i   (alu_dat),
        .alu_stall_o (alu_stall),
        .lsu_valid_i (lsu_valid),
        .lsu_adr_i   (lsu_adr),
        .lsu_dat_i   (lsu_dat),
        .lsu_ready_o (lsu_ready),
        .dbg_req_i   (dbg_req),
        .dbg_adr_i   (dbg_adr),
        .dbg_dat_i   (dbg_dat),
        .dbg_ack_o   (dbg_ack),
        .chk_adr_a_i (chk_a),
        .chk_adr_b_i (chk_b),
        .hazard_o    (hazard),
        .rf_we_o     (rf_we),
        .rf_adr_o    (rf_adr),
        .rf_dat_o    (rf_dat),
        .pending_o   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.adr = a;
        w.dat = d;
        exp_q.push_back(w);
    endtask

    task automatic alu(input logic we, input logic [4:0] a, input logic [31:0] d);
        alu_we  = we;
        alu_adr = a;
        alu_dat = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lsu_valid = v;
        lsu_adr   = a;
        lsu_dat   = d;
    endtask

    // Monitor: every RF write must match the oldest expected write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got adr=%0d dat=0x%0h, expected no write at %0t",
                             rf_adr, rf_dat, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("rf_adr", 32'(rf_adr), 32'(w.adr));
                    check("rf_dat", rf_dat, w.dat);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        dbg_req = 1'b0;
        dbg_adr = 5'd0;
        dbg_dat = 32'h0;
        chk_a   = 5'd1;
        chk_b   = 5'd1;
        repeat (3) nxt();
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ready", 32'(lsu_ready), 32'd1);
        check("rst_hazard", 32'(hazard), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_stall", 32'(alu_stall), 32'd0);
        rst_n = 1'b1;

        // ALU only
        nxt();
        alu(1'b1, 5'd3, 32'h1234); #1;
        check("alu_stall_plain", 32'(alu_stall), 32'd0);
        expect_wr(5'd3, 32'h1234);
        nxt();
        alu(1'b0, 5'd0, 32'h0);

        // LSU back-to-back with ALU idle: each entry drains the next cycle
        nxt(); lsu(1'b1, 5'd5, 32'h50); #1;
        check("b2b_ready0", 32'(lsu_ready), 32'd1); expect_wr(5'd5, 32'h50);
        nxt(); lsu(1'b1, 5'd6, 32'h60); #1;
        check("b2b_ready1", 32'(lsu_ready), 32'd1); expect_wr(5'd6, 32'h60);
        nxt(); lsu(1'b1, 5'd7, 32'h70); #1;
        check("b2b_ready2", 32'(lsu_ready), 32'd1); expect_wr(5'd7, 32'h70);
        nxt(); lsu(1'b0, 5'd0, 32'h0);
        nxt(); nxt();
        check("b2b_drained", 32'(pending), 32'd0);

        // ALU busy: fill FIFO, third push blocked, drain in order
        nxt(); alu(1'b1, 5'd10, 32'hA0); lsu(1'b1, 5'd5, 32'h55); expect_wr(5'd10, 32'hA0);
        nxt(); alu(1'b1, 5'd11, 32'hA1); lsu(1'b1, 5'd6, 32'h66); expect_wr(5'd11, 32'hA1); #1;
        check("fill_ready1", 32'(lsu_ready), 32'd1);
        nxt(); alu(1'b1, 5'd12, 32'hA2); lsu(1'b1, 5'd7, 32'h77); expect_wr(5'd12, 32'hA2); #1;
        check("full_pending", 32'(pending), 32'd2);
        check("full_ready", 32'(lsu_ready), 32'd0);
        nxt(); alu(1'b0, 5'd0, 32'h0); lsu(1'b0, 5'd0, 32'h0);
        expect_wr(5'd5, 32'h55); expect_wr(5'd6, 32'h66); #1;
        check("full_pending_held", 32'(pending), 32'd2);
        nxt(); nxt(); nxt();
        check("drain_pending", 32'(pending), 32'd0);

        // Starvation: ALU always requesting, LSU head forced through after the limit
        nxt(); alu(1'b1, 5'd20, 32'hC0); lsu(1'b1, 5'd9, 32'hAA); expect_wr(5'd20, 32'hC0); #1;
        check("stv_stall_p0", 32'(alu_stall), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            nxt(); alu(1'b1, 5'(20 + k), 32'hC0 + 32'(k)); lsu(1'b0, 5'd0, 32'h0);
            expect_wr(5'(20 + k), 32'hC0 + 32'(k)); #1;
            check("stv_stall_win", 32'(alu_stall), 32'd0);
        end
        nxt(); alu(1'b1, 5'd25, 32'hC5); expect_wr(5'd9, 32'hAA); #1;
        check("stv_stall_on", 32'(alu_stall), 32'd1);
        check("stv_pending", 32'(pending), 32'd1);
        nxt(); expect_wr(5'd25, 32'hC5); #1;
        check("stv_stall_off", 32'(alu_stall), 32'd0);
        nxt(); alu(1'b0, 5'd0, 32'h0);

        // Debug lowest priority
        nxt(); dbg_req = 1'b1; dbg_adr = 5'd2; dbg_dat = 32'h55;
        for (int k = 0; k < 3; k++) begin
            alu(1'b1, 5'(13 + k), 32'hD0 + 32'(k)); expect_wr(5'(13 + k), 32'hD0 + 32'(k));
            nxt(); check("dbg_no_ack", 32'(dbg_ack), 32'd0);
        end
        alu(1'b0, 5'd0, 32'h0); expect_wr(5'd2, 32'h55);
        nxt(); check("dbg_ack", 32'(dbg_ack), 32'd1);
        dbg_req = 1'b0;
        nxt(); check("dbg_ack_pulse", 32'(dbg_ack), 32'd0);

        // Hazard on a queued load to r4
        nxt(); chk_a = 5'd1; chk_b = 5'd4;
        alu(1'b1, 5'd16, 32'hE0); lsu(1'b1, 5'd4, 32'h44); expect_wr(5'd16, 32'hE0); #1;
        check("haz_empty", 32'(hazard), 32'd0);
        nxt(); alu(1'b1, 5'd17, 32'hE1); lsu(1'b0, 5'd0, 32'h0); expect_wr(5'd17, 32'hE1); #1;
        check("haz_queued", 32'(hazard), 32'd1);
        nxt(); alu(1'b0, 5'd0, 32'h0); chk_a = 5'd4; chk_b = 5'd1; expect_wr(5'd4, 32'h44); #1;
        check("haz_pop_cycle", 32'(hazard), 32'd1);
        nxt(); #1;
        check("haz_after_pop", 32'(hazard), 32'd0);

        // r0: ALU write and queued load to r0 never write, never flag a hazard
        nxt(); chk_a = 5'd0; chk_b = 5'd0;
        alu(1'b1, 5'd0, 32'hDEAD); lsu(1'b1, 5'd0, 32'h77);
        nxt(); alu(1'b1, 5'd28, 32'hF0); lsu(1'b0, 5'd0, 32'h0); expect_wr(5'd28, 32'hF0); #1;
        check("r0_alu_no_we", 32'(rf_we), 32'd0);
        check("r0_hazard", 32'(hazard), 32'd0);
        check("r0_pending", 32'(pending), 32'd1);
        nxt(); alu(1'b0, 5'd0, 32'h0);
        nxt(); #1;
        check("r0_pop_no_we", 32'(rf_we), 32'd0);
        check("r0_popped", 32'(pending), 32'd0);

        // Reset with two loads queued
        nxt(); chk_a = 5'd21; chk_b = 5'd1;
        alu(1'b1, 5'd18, 32'hB0); lsu(1'b1, 5'd21, 32'h21); expect_wr(5'd18, 32'hB0);
        nxt(); alu(1'b1, 5'd19, 32'hB1); lsu(1'b1, 5'd22, 32'h22); expect_wr(5'd19, 32'hB1);
        nxt(); alu(1'b1, 5'd26, 32'hB2); lsu(1'b0, 5'd0, 32'h0); expect_wr(5'd26, 32'hB2); #1;
        check("rq_pending", 32'(pending), 32'd2);
        check("rq_hazard", 32'(hazard), 32'd1);
        nxt(); alu(1'b0, 5'd0, 32'h0); #1;
        rst_n = 1'b0; #1;
        check("rq_rst_pending", 32'(pending), 32'd0);
        check("rq_rst_ready", 32'(lsu_ready), 32'd1);
        check("rq_rst_hazard", 32'(hazard), 32'd0);
        nxt(); nxt(); rst_n = 1'b1;
        nxt(); check("rq_rel_no_we", 32'(rf_we), 32'd0);
        nxt(); check("rq_rel_no_we2", 32'(rf_we), 32'd0);
        check("rq_rel_pending", 32'(pending), 32'd0);
        repeat (3) nxt();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mor1kx_rf_wb_sched.md
Name: mor1kx_rf_wb_sched

Overview:
- Schedules the single GPR write port of the register file between three writeback sources:
  - the ALU/execute result, which has priority and does not back-pressure;
  - load returns from the LSU, buffered in a small FIFO;
  - debug-unit GPR writes.
- Produces the registered write strobe, address and data that drive the register file write port.
- Reports read-after-write hazards against loads still queued in the FIFO, so decode can stall.

Parameters:
- OPTION_RF_ADDR_WIDTH, 5: GPR address width.
- OPTION_OPERAND_WIDTH, 32: data width.
- OPTION_LSU_FIFO_DEPTH, 2: load-return FIFO entries; must be a power of 2, at least 2.
- OPTION_STARVE_LIMIT, 4: number of consecutive cycles the LSU head may lose arbitration before the ALU is stalled.
- OPTION_R0_ZERO, 1: when 1, writes to r0 are accepted but suppressed.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- alu_we_i, in, 1: ALU write request; single-cycle, not held.
- alu_adr_i, in, OPTION_RF_ADDR_WIDTH: ALU destination register.
- alu_dat_i, in, OPTION_OPERAND_WIDTH: ALU result.
- alu_stall_o, out, 1: ALU request not taken this cycle; upstream holds it.
- lsu_valid_i, in, 1: load data valid.
- lsu_adr_i, in, OPTION_RF_ADDR_WIDTH: load destination register.
- lsu_dat_i, in, OPTION_OPERAND_WIDTH: load data.
- lsu_ready_o, out, 1: FIFO can accept a load return.
- dbg_req_i, in, 1: debug GPR write request; level, held until ack.
- dbg_adr_i, in, OPTION_RF_ADDR_WIDTH: debug destination register.
- dbg_dat_i, in, OPTION_OPERAND_WIDTH: debug write data.
- dbg_ack_o, out, 1: one-cycle pulse when the debug write is granted.
- chk_adr_a_i, in, OPTION_RF_ADDR_WIDTH: decode source A address.
- chk_adr_b_i, in, OPTION_RF_ADDR_WIDTH: decode source B address.
- hazard_o, out, 1: a source address matches a queued load.
- rf_we_o, out, 1: register file write enable.
- rf_adr_o, out, OPTION_RF_ADDR_WIDTH: register file write address.
- rf_dat_o, out, OPTION_OPERAND_WIDTH: register file write data.
- pending_o, out, log2(OPTION_LSU_FIFO_DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cleared: FIFO pointers, occupancy, starve counter, rf_we_o/rf_adr_o/rf_dat_o, dbg_ack_o, alu_stall_o;
  - lsu_ready_o=1 and hazard_o=0 while in reset.
  - Reset mid-operation discards queued loads and any in-flight grant; no write issues on the first cycle after release.
- FIFO push: occurs when lsu_valid_i && lsu_ready_o.
  - lsu_ready_o = !full, derived from registered state only; a pop in the same cycle does not open a slot.
  - Pushing while lsu_ready_o=0 is ignored (protocol violation).
- Arbitration, one grant per cycle, evaluated on the current-cycle state:
  1. starve = (starve_cnt == OPTION_STARVE_LIMIT) && !empty. If starve: LSU head granted; alu_stall_o=1, combinational; ALU request not taken.
  2. Else if alu_we_i: ALU granted; alu_stall_o=0.
  3. Else if !empty: FIFO head granted and popped.
  4. Else if dbg_req_i: debug granted; dbg_ack_o=1 on the next cycle; debug holds the request low in the cycle dbg_ack_o is high.
- alu_stall_o is 1 only when alu_we_i && starve.
- Starve counter:
  - increments, saturating at OPTION_STARVE_LIMIT, each cycle the FIFO is non-empty and the head is not granted;
  - clears on any LSU grant, or when the FIFO is empty.
- Grant latency: rf_we_o/rf_adr_o/rf_dat_o are registered, valid the cycle after the grant; rf_we_o is high for exactly one cycle per grant.
- r0 handling: with OPTION_R0_ZERO=1, a grant to address 0 still pops the FIFO or acks debug, but rf_we_o stays 0.
- Push and pop of the same entry in one cycle is impossible; a new push becomes eligible the following cycle.
- Wrap-around: pointers wrap modulo OPTION_LSU_FIFO_DEPTH; occupancy is carried in pending_o with one extra bit.
- hazard_o (combinational): 1 if any valid FIFO entry address equals chk_adr_a_i or chk_adr_b_i.
  - Address 0 never matches when OPTION_R0_ZERO=1.
  - The entry being popped this cycle still counts.
  - Entries already written into the register file do not count.

Test Plan:
- ALU only: alu_we_i=1, adr=3, dat=0x1234 for 1 cycle -> next cycle rf_we_o=1, rf_adr_o=3, rf_dat_o=0x1234; alu_stall_o=0.
- LSU fill/drain:
  - 3 back-to-back pushes to r5/r6/r7 with ALU idle -> lsu_ready_o stays 1, since each entry pops one cycle after its push;
  - with the ALU busy, 2 pushes -> pending_o=2, lsu_ready_o=0 and the third push is blocked;
  - once the ALU is released, r5 and then r6 are written in order.
- Starvation (OPTION_STARVE_LIMIT=4): LSU push r9=0xAA, ALU continuously requesting -> ALU wins 4 cycles, the 5th cycle has alu_stall_o=1, the LSU is granted and r9=0xAA is written the next cycle; the ALU resumes after that.
- Debug lowest priority: dbg_req_i to r2=0x55 with the ALU busy for 3 cycles -> no ack; once idle, the next cycle gives dbg_ack_o=1 and rf_we_o with r2=0x55.
- Hazard/r0:
  - queued load to r4 with chk_adr_b_i=4 -> hazard_o=1 until the cycle after the pop;
  - ALU write to r0 -> rf_we_o=0.
- Reset mid-queue: 2 entries queued, rst_n pulsed low -> pending_o=0, lsu_ready_o=1, hazard_o=0, no rf_we_o after release.
